// File: rtl/fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter
//
// Round-robin arbiter sharing the single write port of the 16x8 FIFO
// (FIFO_Control + ram16x8) among N requesters.  A grant turns into a
// one-cycle write strobe.  The cycle after each grant is a mandatory gap.
// That gap lets the requester react to ack, and it lets FIFO_Control update
// full before the next decision is made.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset (has priority over everything)
//   req         [N-1:0]   request per requester
//   data_in     [N*W-1:0] flattened data, requester i at [i*W +: W]
//   full        FIFO full flag from FIFO_Control
//   ack         [N-1:0]   one-hot, one-cycle pulse: word of requester taken
//   wr          one-cycle write strobe to FIFO_Control
//   wr_data     [W-1:0]   word to RAM data input, valid while wr=1
//   last_grant  [LG_W-1:0] index of most recently granted requester
//   wr_count    [7:0]     words written since reset, wraps 255->0
// ---------------------------------------------------------------------------
module fifo_write_arbiter #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int LG_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      req,
    input  logic [N*W-1:0]    data_in,
    input  logic              full,
    output logic [N-1:0]      ack,
    output logic              wr,
    output logic [W-1:0]      wr_data,
    output logic [LG_W-1:0]   last_grant,
    output logic [7:0]        wr_count
);

    localparam int SUM_W = LG_W + 1;
    localparam logic [SUM_W-1:0] N_S = SUM_W'(N);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [N-1:0]       ack_reg, ack_next;
    logic               wr_reg, wr_next;
    logic [W-1:0]       wr_data_reg, wr_data_next;
    logic [LG_W-1:0]    last_grant_reg, last_grant_next;
    logic [7:0]         wr_count_reg, wr_count_next;

    // Unpacked view of the flattened data bus.
    logic [W-1:0]       data_arr [N];

    // cand_idx[k] is the requester checked at priority position k, where
    // position 0 is the one just after the last grant (circular).
    logic [SUM_W-1:0]   cand_sum [N];
    logic [LG_W-1:0]    cand_idx [N];

    logic               grant_found;
    logic [LG_W-1:0]    grant_idx;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slice
            assign data_arr[gi] = data_in[gi*W +: W];
            // last_grant <= N-1 and offset <= N, so the sum stays below 2N
            // and a single conditional subtract implements mod N.
            assign cand_sum[gi] = {1'b0, last_grant_reg} + SUM_W'(gi + 1);
            assign cand_idx[gi] = (cand_sum[gi] >= N_S) ?
                                  LG_W'(cand_sum[gi] - N_S) :
                                  cand_sum[gi][LG_W-1:0];
        end
    endgenerate

    // First requesting candidate in rotated priority order.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!grant_found && req[cand_idx[k]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[k];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_next      = state_reg;
        ack_next        = '0;
        wr_next         = 1'b0;
        wr_data_next    = wr_data_reg;
        last_grant_next = last_grant_reg;
        wr_count_next   = wr_count_reg;

        case (state_reg)
            IDLE: begin
                if (!full && grant_found) begin
                    ack_next[grant_idx] = 1'b1;
                    wr_next             = 1'b1;
                    wr_data_next        = data_arr[grant_idx];
                    last_grant_next     = grant_idx;
                    wr_count_next       = wr_count_reg + 8'd1;
                    state_next          = GRANT;
                end
            end
            GRANT: begin
                // Gap cycle: no decision, strobes drop back to 0.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            ack_reg        <= '0;
            wr_reg         <= 1'b0;
            wr_data_reg    <= '0;
            // N-1 so that requester 0 is first in line after reset.
            last_grant_reg <= LG_W'(N - 1);
            wr_count_reg   <= 8'd0;
        end else begin
            state_reg      <= state_next;
            ack_reg        <= ack_next;
            wr_reg         <= wr_next;
            wr_data_reg    <= wr_data_next;
            last_grant_reg <= last_grant_next;
            wr_count_reg   <= wr_count_next;
        end
    end

    assign ack        = ack_reg;
    assign wr         = wr_reg;
    assign wr_data    = wr_data_reg;
    assign last_grant = last_grant_reg;
    assign wr_count   = wr_count_reg;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_write_arbiter
//
// Scoreboard bench for fifo_write_arbiter (N=4, W=8).  Stimulus pushes the
// expected write (ack, data, last_grant, wr_count) into a queue; a monitor
// on the falling edge pops one entry per wr pulse and compares.  A small
// 16-deep occupancy counter stands in for FIFO_Control to produce full.
// ---------------------------------------------------------------------------
module tb_fifo_write_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] data_in;
    logic           full;
    logic [N-1:0]   ack;
    logic           wr;
    logic [W-1:0]   wr_data;
    logic [1:0]     last_grant;
    logic [7:0]     wr_count;

    logic [W-1:0]   d [N];
    assign data_in = {d[3], d[2], d[1], d[0]};

    fifo_write_arbiter #(.N(N), .W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .data_in    (data_in),
        .full       (full),
        .ack        (ack),
        .wr         (wr),
        .wr_data    (wr_data),
        .last_grant (last_grant),
        .wr_count   (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- FIFO occupancy stand-in ------------------------------------------
    int   fifo_cnt;
    logic rd;
    logic auto_rd;
    logic rd_eff;
    assign rd_eff = rd | (auto_rd && (fifo_cnt > 0));
    assign full   = (fifo_cnt == 16);

    always @(posedge clk) begin
        if (reset) fifo_cnt <= 0;
        else fifo_cnt <= fifo_cnt + ((wr && fifo_cnt < 16) ? 1 : 0)
                                  - ((rd_eff && fifo_cnt > 0) ? 1 : 0);
    end

    // ---- scoreboard ---------------------------------------------------------
    typedef struct {
        logic [N-1:0] ack;
        logic [W-1:0] data;
        logic [1:0]   lg;
        logic [7:0]   cnt;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] exp_cnt;
    int         n_cmp;
    int         n_err;
    logic       mon_en;
    logic       prev_wr;
    logic       prev_full;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req_v, $time);
        end
    endtask

    task automatic push(input logic [N-1:0] a, input logic [W-1:0] dv, input logic [1:0] lg);
        exp_t e;
        exp_cnt = exp_cnt + 8'd1;
        e.ack  = a;
        e.data = dv;
        e.lg   = lg;
        e.cnt  = exp_cnt;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (wr) begin
                exp_t e;
                check("back_to_back_wr", 32'(prev_wr), 32'd0);
                check("wr_while_full", 32'(prev_full), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_wr", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack", 32'(ack), 32'(e.ack));
                    check("wr_data", 32'(wr_data), 32'(e.data));
                    check("last_grant", 32'(last_grant), 32'(e.lg));
                    check("wr_count", 32'(wr_count), 32'(e.cnt));
                    $display("write: ack=%b data=%02h lg=%0d cnt=%0d", ack, wr_data, last_grant, wr_count);
                end
            end else begin
                check("ack_without_wr", 32'(ack), 32'd0);
            end
            prev_wr   <= wr;
            prev_full <= full;
        end
    end

    // ---- stimulus helpers ---------------------------------------------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        exp_cnt = 8'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Returns at posedge+1 right after the n-th ack becomes visible.
    task automatic wait_acks(input string name, input int n, input int budget);
        int got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            @(posedge clk);
            #1;
            if (|ack) got++;
        end
        if (got < n) check({"timeout_", name}, 32'(got), 32'(n));
    endtask

    // ---- directed tests -----------------------------------------------------
    initial begin
        n_cmp = 0; n_err = 0; mon_en = 1'b0;
        prev_wr = 1'b0; prev_full = 1'b0;
        req = '0; rd = 1'b0; auto_rd = 1'b0; exp_cnt = 8'd0;
        for (int i = 0; i < N; i++) d[i] = '0;
        reset = 1'b1;
        idle(3);
        do_reset();
        mon_en = 1'b1;

        // Reset state
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_wr", 32'(wr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_last_grant", 32'(last_grant), 32'd3);
        check("rst_wr_count", 32'(wr_count), 32'd0);

        // 1: single request, dropped at ack
        d[0] = 8'h11; req = 4'b0001;
        push(4'b0001, 8'h11, 2'd0);
        wait_acks("t1", 1, 10);
        req = 4'b0000;
        idle(4);
        check("t1_count", 32'(wr_count), 32'd1);
        check("t1_pending", 32'(exp_q.size()), 32'd0);

        // 2: all requesting, rotation 0,1,2,3,0
        do_reset();
        for (int i = 0; i < N; i++) d[i] = 8'hA0 + 8'(i);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) push(4'b0001 << (i % 4), 8'hA0 + 8'(i % 4), 2'(i % 4));
        wait_acks("t2", 5, 20);
        req = 4'b0000;
        idle(4);
        check("t2_pending", 32'(exp_q.size()), 32'd0);

        // 3: fill the FIFO, stall on full, release with one read
        do_reset();
        d[2] = 8'h01; req = 4'b0100;
        for (int i = 0; i < 16; i++) push(4'b0100, 8'h01, 2'd2);
        idle(40);
        check("t3_full", 32'(full), 32'd1);
        check("t3_count_stall", 32'(wr_count), 32'd16);
        check("t3_pending", 32'(exp_q.size()), 32'd0);
        push(4'b0100, 8'h01, 2'd2);
        rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
        wait_acks("t3", 1, 10);
        req = 4'b0000;
        idle(4);
        check("t3_count_after_read", 32'(wr_count), 32'd17);
        check("t3_pending2", 32'(exp_q.size()), 32'd0);

        // 4: last_grant=1, req 1001 -> 3 then 0
        do_reset();
        d[1] = 8'h22; req = 4'b0010;
        push(4'b0010, 8'h22, 2'd1);
        wait_acks("t4a", 1, 10);
        req = 4'b0000;
        idle(2);
        d[0] = 8'h33; d[3] = 8'h44; req = 4'b1001;
        push(4'b1000, 8'h44, 2'd3);
        push(4'b0001, 8'h33, 2'd0);
        wait_acks("t4b", 2, 10);
        req = 4'b0000;
        idle(4);
        check("t4_pending", 32'(exp_q.size()), 32'd0);

        // 5: reset during the GRANT cycle
        do_reset();
        d[0] = 8'h55; d[1] = 8'h66; req = 4'b0001;
        push(4'b0001, 8'h55, 2'd0);
        wait_acks("t5a", 1, 10);
        req = 4'b0011;
        do_reset();
        check("t5_ack", 32'(ack), 32'd0);
        check("t5_wr", 32'(wr), 32'd0);
        check("t5_count", 32'(wr_count), 32'd0);
        check("t5_last_grant", 32'(last_grant), 32'd3);
        push(4'b0001, 8'h55, 2'd0);
        push(4'b0010, 8'h66, 2'd1);
        wait_acks("t5b", 2, 10);
        req = 4'b0000;
        idle(4);
        check("t5_pending", 32'(exp_q.size()), 32'd0);

        // 6: 256 writes with draining reads -> wr_count wraps to 0
        do_reset();
        auto_rd = 1'b1;
        d[0] = 8'h5A; req = 4'b0001;
        for (int i = 0; i < 256; i++) push(4'b0001, 8'h5A, 2'd0);
        wait_acks("t6", 256, 1200);
        req = 4'b0000;
        idle(4);
        check("t6_count_wrap", 32'(wr_count), 32'd0);
        check("t6_pending", 32'(exp_q.size()), 32'd0);
        auto_rd = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
Round-robin arbiter that shares the single write port of the 16x8 FIFO (FIFO_Control plus ram16x8) among N requesters. It samples requests, picks one fairly, and forwards that requester's byte as a one-cycle write strobe. It holds off while the FIFO reports full. It sits between the producer logic (switch or pattern sources) and the FIFO write input on the DE1_SoC top level.

Parameters:
N, 4, number of requesters (2..8)
W, 8, data width per requester; matches the RAM word width

Ports:
clk  input  1  system clock (clkSelect at top level)
reset  input  1  synchronous, active-high reset
req  input  N  request per requester; bit i high means data_in slice i holds a valid word
data_in  input  N*W  flattened data; requester i occupies bits [i*W +: W]
full  input  1  FIFO full flag from FIFO_Control
ack  output  N  one-hot, one-cycle pulse; the requester's word has been taken
wr  output  1  one-cycle write strobe to the FIFO_Control write input
wr_data  output  W  word to the RAM data input; valid while wr=1
last_grant  output  clog2(N)  index of the most recently granted requester
wr_count  output  8  total words written since reset; wraps 255->0

Behaviour:
- All outputs are registered and update on posedge clk.
- Reset (synchronous, takes priority over everything, including mid-grant):
  - state=IDLE, ack=0, wr=0, wr_data=0, last_grant=N-1 (so requester 0 has first priority), wr_count=0.
- FSM states: IDLE, GRANT.
- IDLE:
  - If full=0 and |req=1, choose g = first index with req[g]=1, scanning circularly from last_grant+1 mod N.
  - At the next edge: ack<=onehot(g), wr<=1, wr_data<=data_in[g], last_grant<=g, wr_count<=wr_count+1, state<=GRANT.
  - Otherwise ack=0, wr=0, stay IDLE; wr_data holds its previous value.
- GRANT (exactly 1 cycle):
  - ack<=0, wr<=0, state<=IDLE; no new grant is made.
  - This gives the requester one cycle to drop req or present new data after seeing ack.
  - FIFO_Control samples wr during this cycle, so full is up to date at the next IDLE decision.
  - Peak throughput is 1 word per 2 cycles.
- Requester rule: data_in[i] must be stable while req[i]=1. If req[i] is still high in the cycle after ack[i], that is a new word.
- full=1 in IDLE: no grant; requests wait with no loss and no ack. full rising during GRANT does not cancel the in-flight write, because the decision was made with full=0.
- Fairness: a requester holding req high continuously is served at least once every N grants. Example: N=4 with all requesting gives grant order 0,1,2,3,0,...
- req dropped before it is granted: it is simply not considered; no state is kept per requester.
- The arbiter never issues wr while full=1 was sampled at the decision edge. The arbiter never issues two writes in consecutive cycles.
- At most one ack bit is high in any cycle, and ack is high exactly when wr is high.
- Empty/read side is not touched by this block.

Test Plan:
1. Reset, then req=4'b0001 with data0=8'h11 held for 1 cycle before being dropped at ack -> one wr pulse with wr_data=8'h11, ack=4'b0001, last_grant=0, wr_count=1; no second write.
2. req=4'b1111 held continuously, data_i=8'hA0+i -> wr pulses every 2nd cycle, wr_data sequence A0,A1,A2,A3,A0, ack rotating 0001,0010,0100,1000,0001.
3. Fill: req=4'b0100 with data 8'h01 held 40 cycles, FIFO initially empty -> exactly 16 writes, full rises, then wr stays 0 and wr_count stays 16. Read one word (SW9) -> exactly one more write, wr_count=17.
4. last_grant=1, req=4'b1001 -> requester 3 is granted before requester 0. Next grant goes to 0 if still requesting.
5. Assert reset in the GRANT cycle -> next edge ack=0, wr=0, wr_count=0, last_grant=N-1, state IDLE. Then req=4'b0011 -> requester 0 is granted first.
6. wr_count wrap: 256 writes with interleaved reads keeping the FIFO not full -> wr_count returns to 0; no spurious ack.
